color_correction_matrix: RTL and testbench

- Sits directly downstream of the demosaic stage and consumes its 8-bit R/G/B pixel stream and valid strobe.
- Applies a programmable 3x3 signed colour-correction matrix, then rounds and clamps each channel back to 8 bits.
- Tracks the frame pixel count and pulses a done flag on the last pixel of each frame.
- Coefficients are double-buffered so a matrix update never lands mid-frame.

---
 rtl/color_correction_matrix.sv | 182 ++++++++++++++++++
 tb/tb_color_correction_matrix.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_correction_matrix.sv
// 3x3 signed colour-correction matrix with round/clamp to 8 bits, frame pixel counter and
// frame-aligned double-buffered coefficients. Define CCM_OFFSET_EN for per-channel post-shift offsets.
module color_correction_matrix #(
    parameter int width     = 1920,
    parameter int height    = 1080,
    parameter int coefWidth = 12,
    parameter int fracBits  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  iR,
    input  logic [7:0]                  iG,
    input  logic [7:0]                  iB,
    input  logic                        iValid,
    input  logic                        cfgWe,
    input  logic [3:0]                  cfgAddr,
    input  logic signed [coefWidth-1:0] cfgData,
    input  logic                        cfgCommit,
    output logic [7:0]                  oR,
    output logic [7:0]                  oG,
    output logic [7:0]                  oB,
    output logic                        oValid,
    output logic                        oDone,
    output logic [31:0]                 pixCnt,
    output logic                        commitPending
);

    localparam int PW = coefWidth + 9;
    localparam int SW = PW + 2;
    localparam logic [31:0]                  LAST_PIX = 32'(width * height - 1);
    localparam logic signed [SW-1:0]         ROUND    = SW'(1 << (fracBits - 1));
    localparam logic signed [coefWidth-1:0]  UNITY    = coefWidth'(1 << fracBits);

    logic signed [coefWidth-1:0] shadow_q [9];
    logic signed [coefWidth-1:0] shadow_d [9];
    logic signed [coefWidth-1:0] active_q [9];
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic        pend_q, pend_d;
    logic        frame_end, commit_idle, apply;

    logic [7:0]             pix [3];
    logic signed [PW-1:0]   prod_d [9];
    logic signed [PW-1:0]   prod_q [9];
    logic signed [SW-1:0]   sum_d [3];
    logic signed [SW-1:0]   sum_q [3];
    logic signed [SW-1:0]   shifted [3];
    logic signed [SW:0]     adj [3];
    logic [7:0]             clamp_d [3];
    logic [7:0]             out_q [3];
    logic signed [8:0]      off_s3 [3];
    logic valid_s1_q, valid_s2_q, valid_o_q;
    logic done_s1_q, done_s2_q, done_o_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shadow_d = shadow_q;
        if (cfgWe && cfgAddr < 4'd9) shadow_d[cfgAddr] = cfgData;
    end

    // A commit lands immediately only between frames; otherwise it waits for the frame-end pixel.
    assign frame_end   = iValid && (pix_cnt_q == LAST_PIX);
    assign commit_idle = cfgCommit && (pix_cnt_q == '0) && !iValid;
    assign apply       = commit_idle || (frame_end && (pend_q || cfgCommit));

    always_comb begin
        pend_d    = apply ? 1'b0 : (pend_q || cfgCommit);
        pix_cnt_d = pix_cnt_q;
        if (iValid) pix_cnt_d = frame_end ? '0 : pix_cnt_q + 32'd1;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                shadow_q[k] <= (k % 4 == 0) ? UNITY : '0;
                active_q[k] <= (k % 4 == 0) ? UNITY : '0;
            end
            pix_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            if (apply) active_q <= shadow_d;
            pix_cnt_q <= pix_cnt_d;
            pend_q    <= pend_d;
        end
    end

`ifdef CCM_OFFSET_EN
    logic signed [8:0] shadow_off_q [3];
    logic signed [8:0] shadow_off_d [3];
    logic signed [8:0] active_off_q [3];
    logic signed [8:0] off_s1_q [3];
    logic signed [8:0] off_s2_q [3];

    always_comb begin
        shadow_off_d = shadow_off_q;
        if (cfgWe) begin
            case (cfgAddr)
                4'd9:    shadow_off_d[0] = cfgData[8:0];
                4'd10:   shadow_off_d[1] = cfgData[8:0];
                4'd11:   shadow_off_d[2] = cfgData[8:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                shadow_off_q[c] <= '0;
                active_off_q[c] <= '0;
            end
        end else begin
            shadow_off_q <= shadow_off_d;
            if (apply) active_off_q <= shadow_off_d;
        end
    end

    // Offsets ride along with the pixel so S3 uses the set sampled at S1.
    always_ff @(posedge clk) begin
        off_s1_q <= active_off_q;
        off_s2_q <= off_s1_q;
    end

    assign off_s3 = off_s2_q;
`else
    always_comb begin
        for (int c = 0; c < 3; c++) off_s3[c] = '0;
    end
`endif

    always_comb begin
        pix[0] = iR;
        pix[1] = iG;
        pix[2] = iB;
        for (int k = 0; k < 9; k++)
            prod_d[k] = PW'($signed({1'b0, pix[k % 3]})) * PW'(active_q[k]);
        for (int c = 0; c < 3; c++) begin
            sum_d[c]   = SW'(prod_q[3*c]) + SW'(prod_q[3*c+1]) + SW'(prod_q[3*c+2]) + ROUND;
            shifted[c] = sum_q[c] >>> fracBits;
            adj[c]     = (SW+1)'(shifted[c]) + (SW+1)'(off_s3[c]);
            if (adj[c][SW])                 clamp_d[c] = 8'd0;
            else if (adj[c] > (SW+1)'(255)) clamp_d[c] = 8'd255;
            else                            clamp_d[c] = adj[c][7:0];
        end
    end

    // NOTE: pure datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        sum_q  <= sum_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_s1_q <= 1'b0;
            valid_s2_q <= 1'b0;
            valid_o_q  <= 1'b0;
            done_s1_q  <= 1'b0;
            done_s2_q  <= 1'b0;
            done_o_q   <= 1'b0;
            for (int c = 0; c < 3; c++) out_q[c] <= '0;
        end else begin
            valid_s1_q <= iValid;
            valid_s2_q <= valid_s1_q;
            valid_o_q  <= valid_s2_q;
            done_s1_q  <= frame_end;
            done_s2_q  <= done_s1_q;
            done_o_q   <= done_s2_q;
            out_q      <= clamp_d;
        end
    end

    assign oR            = out_q[0];
    assign oG            = out_q[1];
    assign oB            = out_q[2];
    assign oValid        = valid_o_q;
    assign oDone         = done_o_q;
    assign pixCnt        = pix_cnt_q;
    assign commitPending = pend_q;

endmodule

// File: tb/tb_color_correction_matrix.sv
// Scoreboard bench for color_correction_matrix (4x2 frames): directed pixels with hand-computed
// results are queued by the driver and checked by an independent output monitor.
module tb_color_correction_matrix;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        iR = '0, iG = '0, iB = '0;
    logic              iValid = 1'b0;
    logic              cfgWe = 1'b0;
    logic [3:0]        cfgAddr = '0;
    logic signed [11:0] cfgData = '0;
    logic              cfgCommit = 1'b0;
    logic [7:0]        oR, oG, oB;
    logic              oValid, oDone;
    logic [31:0]       pixCnt;
    logic              commitPending;

    color_correction_matrix #(.width(4), .height(2), .coefWidth(12), .fracBits(8)) dut (
        .clk(clk), .reset(reset),
        .iR(iR), .iG(iG), .iB(iB), .iValid(iValid),
        .cfgWe(cfgWe), .cfgAddr(cfgAddr), .cfgData(cfgData), .cfgCommit(cfgCommit),
        .oR(oR), .oG(oG), .oB(oB), .oValid(oValid), .oDone(oDone),
        .pixCnt(pixCnt), .commitPending(commitPending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] r, g, b;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: every oValid must match the oldest queued expectation, at the queued cycle.
    always @(negedge clk) begin
        exp_t e;
        if (oDone === 1'b1) done_seen++;
        if (oValid === 1'b1) begin
            if (sb.size() == 0) begin
                check("stray_oValid", 32'(oValid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("oR", 32'(oR), 32'(e.r));
                check("oG", 32'(oG), 32'(e.g));
                check("oB", 32'(oB), 32'(e.b));
                check("oDone", 32'(oDone), 32'(e.done));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (oDone === 1'b1) begin
            check("oDone_needs_oValid", 32'(oValid), 32'd1);
        end
    end

    task automatic drive_idle();
        iValid = 1'b0;
        cfgWe = 1'b0;
        cfgCommit = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive_idle();
        end
    endtask

    task automatic cfg(input logic [3:0] addr, input logic signed [11:0] data,
                       input logic we, input logic commit);
        @(posedge clk); #1;
        drive_idle();
        cfgWe = we;
        cfgAddr = addr;
        cfgData = data;
        cfgCommit = commit;
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                        input logic done, input logic commit, input bit push);
        exp_t e;
        @(posedge clk); #1;
        drive_idle();
        iR = r; iG = g; iB = b;
        iValid = 1'b1;
        cfgCommit = commit;
        if (push) begin
            e.r = er; e.g = eg; e.b = eb; e.done = done;
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
    endtask

    // Checks state visible in the current cycle, i.e. before this cycle's inputs are taken.
    task automatic expect_state(input int cnt, input logic pend);
        @(negedge clk);
        check("pixCnt", pixCnt, 32'(cnt));
        check("commitPending", 32'(commitPending), 32'(pend));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive_idle();
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_oValid", 32'(oValid), 32'd0);
        check("rst_oDone", 32'(oDone), 32'd0);
        check("rst_oR", 32'(oR), 32'd0);
        check("rst_oG", 32'(oG), 32'd0);
        check("rst_oB", 32'(oB), 32'd0);
        check("rst_pixCnt", pixCnt, 32'd0);
        check("rst_commitPending", 32'(commitPending), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;

        // Identity after reset
        do_reset();
        send(8'd10, 8'd200, 8'd255, 8'd10, 8'd200, 8'd255, 1'b0, 1'b0, 1'b1);
        idle(6);
        expect_state(1, 1'b0);

        // Overflow clamp: row 0 = (512,0,0), committed while idle
        do_reset();
        cfg(4'd0, 12'sd512, 1'b1, 1'b0);
        cfg(4'd0, 12'sd0, 1'b0, 1'b1);
        expect_state(0, 1'b0);
        idle(1);
        expect_state(0, 1'b0);
        send(8'd200, 8'd20, 8'd30, 8'd255, 8'd20, 8'd30, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Rounding, with the write and commit in the same cycle: (3*128+128)>>8 = 2
        do_reset();
        cfg(4'd0, 12'sd128, 1'b1, 1'b1);
        send(8'd3, 8'd4, 8'd5, 8'd2, 8'd4, 8'd5, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Negative clamp: row 0 = (256,-256,0); address 13 must be ignored
        do_reset();
        cfg(4'd1, -12'sd256, 1'b1, 1'b0);
        cfg(4'd13, 12'sd2047, 1'b1, 1'b0);
        cfg(4'd0, 12'sd0, 1'b0, 1'b1);
        send(8'd10, 8'd50, 8'd0, 8'd0, 8'd50, 8'd0, 1'b0, 1'b0, 1'b1);
        send(8'd100, 8'd30, 8'd9, 8'd70, 8'd30, 8'd9, 1'b0, 1'b0, 1'b1);
        send(8'd255, 8'd0, 8'd1, 8'd255, 8'd0, 8'd1, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Deferred commit: shadow R gain 512, commit at pixel 3, G gain 512 written while pending
        do_reset();
        cfg(4'd0, 12'sd512, 1'b1, 1'b0);
        d0 = done_seen;
        for (int i = 1; i <= 8; i++) begin
            send(8'(10 * i), 8'(i), 8'd100, 8'(10 * i), 8'(i), 8'd100,
                 (i == 8), (i == 3), 1'b1);
            expect_state(i - 1, (i >= 4));
            if (i == 5) cfg(4'd4, 12'sd512, 1'b1, 1'b0);
        end
        idle(1);
        expect_state(0, 1'b0);
        send(8'd20, 8'd5, 8'd100, 8'd40, 8'd10, 8'd100, 1'b0, 1'b0, 1'b1);
        idle(6);
        check("deferred_done_pulses", 32'(done_seen - d0), 32'd1);

        // Two frames with random gaps on iValid
        do_reset();
        d0 = done_seen;
        for (int i = 1; i <= 16; i++) begin
            repeat ($urandom_range(0, 2)) idle(1);
            send(8'(3 * i), 8'(255 - i), 8'(i), 8'(3 * i), 8'(255 - i), 8'(i),
                 (i % 8 == 0), 1'b0, 1'b1);
            expect_state((i - 1) % 8, 1'b0);
        end
        idle(6);
        expect_state(0, 1'b0);
        check("gap_done_pulses", 32'(done_seen - d0), 32'd2);

        // Reset with two pixels in flight and a pending commit
        do_reset();
        cfg(4'd0, 12'sd512, 1'b1, 1'b1);
        send(8'd50, 8'd50, 8'd50, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        send(8'd60, 8'd60, 8'd60, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        expect_state(1, 1'b1);
        do_reset();
        send(8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 1'b0, 1'b0, 1'b1);
        idle(1);
        expect_state(1, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
